mat_result_reader: RTL and testbench
====================================

# mat_result_reader

Consumer side of the multiply datapath's result bus. Waits for the multiply datapath's `finish`, captures the packed 160-bit 4x4 result `mat_out` in one cycle, and streams its 16 elements, 10 bits each, in row-major order over a valid/ready interface. It also reports a 14-bit checksum of all elements when the stream completes. It sits between `Multiply_Path` and the display/output logic.

## Interface

**Parameters**
- `ELEM_W`, default 10: element width. Fixed by the multiply datapath format.
- `N_ELEM`, default 16: elements per matrix, 4x4.
- `SUM_W`, default 14: checksum width. 16 × 900 = 14400 fits without overflow.

**Ports**
- `clk`, input, 1: single clock. All logic is posedge.
- `rst`, input, 1: reset, asynchronous and active-high. Clears all state immediately.
- `finish`, input, 1: level done flag from the multiply datapath. Held high until that block is reset.
- `mat_out`, input, 160: packed result. C11 is at [159:150], C12 at [149:140], and so on row-major, with C44 at [9:0].
- `out_ready`, input, 1: downstream can accept an element this cycle.
- `out_valid`, output, 1: `out_data`, `out_row` and `out_col` hold a valid element.
- `out_data`, output, 10: element value.
- `out_row`, output, 2: row index, 0..3.
- `out_col`, output, 2: column index, 0..3.
- `busy`, output, 1: high while capture or stream is in progress.
- `done`, output, 1: one-cycle pulse after the last element is accepted.
- `checksum`, output, 14: sum of all 16 elements. Valid while `done`=1 and held until the next capture.

## Operation

**Trigger**
- `finish_q` is a registered copy of `finish`.
- A trigger is `finish & ~finish_q` while in IDLE.
- `finish_q` resets to 0. If `finish` is already high when `rst` is released, that counts as a trigger on the first clock.
- A level-held `finish` never re-triggers. A new run needs `finish` to fall and rise again.

**State machine**
- IDLE
  - On trigger: latch `mat_out` into a 160-bit buffer, set `idx`=0, clear the sum accumulator, go to SEND.
  - Otherwise stay in IDLE.
- SEND
  - `out_valid`=1. `out_data` = buffer[159-10*idx -: 10]. `out_row` = idx[3:2]. `out_col` = idx[1:0].
  - On `out_valid & out_ready`: accumulator += `out_data`.
    - If `idx`=15, go to FIN.
    - Otherwise `idx`++ and stay in SEND.
  - Without `out_ready`: all outputs hold stable and `idx` does not advance.
- FIN
  - `done`=1 for exactly one cycle.
  - `checksum` takes the final accumulator value and holds it.
  - Next state is IDLE.
- Triggers arriving in SEND or FIN are ignored. The edge is consumed and not queued.

**Outputs**
- `busy` = (state != IDLE).
- `idx` is a 4-bit counter with no wrap past 15 inside SEND.
- Arithmetic is unsigned. The accumulator is `SUM_W` bits wide and cannot overflow for legal inputs (max element 900).
- `out_data`, `out_row` and `out_col` are driven to 0 whenever `out_valid`=0.

**Reset**
- All outputs are 0 on reset: `out_valid`, `out_data`, `out_row`, `out_col`, `busy`, `done`, `checksum`.
- State goes to IDLE. The buffer, `idx`, accumulator and `finish_q` are cleared.
- Reset mid-stream aborts the stream. No `done` is produced and `checksum` is cleared.

## Timing

- **Trigger to first element:** trigger sampled at edge t gives `out_valid`=1 in the cycle after edge t.
- **Throughput:** with `out_ready` held high, one element is accepted per cycle. Elements transfer in cycles t+1..t+16, and `done` pulses in cycle t+17.
- **Backpressure:** each cycle with `out_ready`=0 in SEND adds exactly one cycle of latency.
- **Combinational paths:** no combinational path from `out_ready` to `out_valid`. `out_valid` depends only on registered state.
- **Capture:** `mat_out` is sampled only on the trigger edge. Later changes to `mat_out` do not affect the stream.
- **Back-to-back runs:** minimum spacing between runs is `finish` low for at least one sampled cycle, then high again.

## Test plan

1. **Index pattern.** Load `mat_out` with element k = k, for k = 0..15, row-major. Raise `finish` with `out_ready`=1. Expect:
   - `out_data` 0,1,…,15 on consecutive cycles, starting one cycle after the trigger.
   - (`out_row`, `out_col`) sequence (0,0),(0,1),…,(3,3).
   - `done` pulses once with `checksum`=120.
2. **Backpressure.** Same data, with `out_ready` toggling 1,0,0,1,… Expect:
   - Each element held stable while `out_ready`=0.
   - No element skipped or duplicated, `checksum`=120.
   - `done` delayed by the count of ready-low cycles.
3. **Maximum values.** All elements = 900. Expect every `out_data`=900 and `checksum`=14400, with no overflow.
4. **Reset mid-stream.** Assert `rst` asynchronously after element 5 is accepted. Expect:
   - All outputs 0 immediately, with no `done`.
   - After release, a fresh `finish` rise restarts at element 0.
5. **Level-held `finish`.** Keep `finish` high for 40 cycles after `done`. Expect no second stream. Drop `finish` for 1 cycle, then raise it with new `mat_out`. Expect a new stream of the new data.
6. **`finish` high at reset release.** Hold `finish`=1 while deasserting `rst`. Expect capture on the first clock, with `out_valid`=1 one cycle later.

Source files
------------

// File: rtl/mat_result_reader.sv
// mat_result_reader
// Captures the 4x4 result matrix from the multiply datapath on the rising
// edge of its level done flag. It then streams the 16 elements in row-major
// order over a valid/ready interface, and reports their sum when the stream
// completes.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   finish     : level done flag from the multiply datapath
//   mat_out    : packed matrix, C11 in the top ELEM_W bits, C44 in the bottom
//   out_ready  : downstream accepts the presented element this cycle
//   out_valid  : out_data/out_row/out_col carry an element
//   out_data   : element value (0 when out_valid=0)
//   out_row    : row index 0..3 (0 when out_valid=0)
//   out_col    : column index 0..3 (0 when out_valid=0)
//   busy       : a capture/stream is in progress
//   done       : one-cycle pulse after the last element is accepted
//   checksum   : sum of all elements, valid with done and held afterwards
//
// Handshake: an element transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid rises, the element stays stable
// until it is accepted. out_valid is decoded from registered state only, so
// out_ready has no combinational path to it.
module mat_result_reader #(
  parameter int ELEM_W = 10,
  parameter int N_ELEM = 16,
  parameter int SUM_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     finish,
  input  logic [ELEM_W*N_ELEM-1:0] mat_out,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ELEM_W-1:0]        out_data,
  output logic [1:0]               out_row,
  output logic [1:0]               out_col,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_W-1:0]         checksum
);

  localparam int BUF_W = ELEM_W * N_ELEM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               finish_q;
  logic [BUF_W-1:0]   buffer;
  logic [3:0]         idx;
  logic [SUM_W-1:0]   acc;
  logic               trigger;
  logic               accept;
  logic               last;

  // Only a rising edge of finish seen in IDLE starts a run. Edges seen in
  // SEND or FIN are dropped, and a held-high finish never re-triggers.
  assign trigger = (state == IDLE) & finish & ~finish_q;
  assign accept  = out_valid & out_ready;
  assign last    = (idx == 4'(N_ELEM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (trigger) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        // The buffer shifts left on every accept, so the current element is
        // always in the top slot.
        out_data  = buffer[BUF_W-1 -: ELEM_W];
        out_row   = idx[3:2];
        out_col   = idx[1:0];
        if (out_ready && last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finish_q <= 1'b0;
      buffer   <= '0;
      idx      <= '0;
      acc      <= '0;
      checksum <= '0;
    end else begin
      finish_q <= finish;
      if (trigger) begin
        buffer <= mat_out;
        idx    <= '0;
        acc    <= '0;
      end else if (accept) begin
        buffer <= buffer << ELEM_W;
        acc    <= acc + SUM_W'(out_data);
        if (last) checksum <= acc + SUM_W'(out_data);
        else      idx      <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mat_result_reader.sv
module tb_mat_result_reader;

  logic         clk;
  logic         rst;
  logic         finish;
  logic [159:0] mat_out;
  logic         out_ready;
  logic         out_valid;
  logic [9:0]   out_data;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         busy;
  logic         done;
  logic [13:0]  checksum;

  int checks = 0;
  int errors = 0;

  // Model: each expected element is {row, col, data}. Each completed run
  // expects one checksum.
  logic [13:0] exp_q[$];
  logic [13:0] sum_q[$];

  mat_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .finish    (finish),
    .mat_out   (mat_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack(input int v[16]);
    logic [159:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[(15 - k) * 10 +: 10] = 10'(v[k]);
    return m;
  endfunction

  task automatic push_elems(input int v[16]);
    for (int k = 0; k < 16; k++) exp_q.push_back({2'(k / 4), 2'(k % 4), 10'(v[k])});
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    if (mode == 1) return (c % 3) == 1;  // 1,0,0,1,0,0,...
    return 1'b1;
  endfunction

  // Scoreboard: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sum_q.delete();
      check("rst_outputs_zero", {out_valid, out_data, out_row, out_col, busy, done, checksum}, 64'd0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else begin
          check("element_rc_data", {out_row, out_col, out_data}, exp_q[0]);
          check("busy_in_send", busy, 64'd1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", {out_data, out_row, out_col}, 64'd0);
      end
      if (done) begin
        check("done_after_all_elems", exp_q.size(), 64'd0);
        if (sum_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("checksum", checksum, sum_q.pop_front());
      end
    end
  end

  // Driver: a run starts with finish sampled low. Finish is left high on return.
  task automatic run(input int v[16], input int exp_ck, input int mode);
    int cycles;
    int lows;
    mat_out = pack(v);
    push_elems(v);
    sum_q.push_back(14'(exp_ck));
    finish = 1'b1;
    @(posedge clk); #1;                    // trigger edge t, now in cycle t+1
    check("first_valid_latency", out_valid, 64'd1);
    check("busy_after_trigger", busy, 64'd1);
    mat_out = ~mat_out;                    // later changes must not reach the stream
    cycles = 1;
    lows   = 0;
    while (!done && cycles < 200) begin
      out_ready = ready_pat(mode, cycles);
      if (out_valid && !out_ready) lows++;
      @(posedge clk); #1;
      cycles++;
    end
    check("done_seen", done, 64'd1);
    check("done_latency", cycles, 17 + lows);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", done, 64'd0);
    check("busy_cleared", busy, 64'd0);
  endtask

  initial begin
    int vi[16];
    int vm[16];
    int vn[16];
    int vs[16];
    for (int k = 0; k < 16; k++) begin
      vi[k] = k;
      vm[k] = 900;
      vn[k] = 3 * k + 7;
      vs[k] = 50 * k;
    end

    rst       = 1'b1;
    finish    = 1'b0;
    mat_out   = '0;
    out_ready = 1'b1;
    #1;
    check("reset_state", {out_valid, out_data, out_row, out_col, busy, done, checksum}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. Index pattern
    run(vi, 120, 0);
    repeat (3) @(posedge clk);
    #1;
    check("checksum_hold", checksum, 64'd120);
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 2. Backpressure
    run(vi, 120, 1);
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3. Maximum values
    run(vm, 14400, 0);
    check("checksum_max", checksum, 64'd14400);
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4. Reset mid-stream, after element 5 is accepted
    mat_out = pack(vi);
    push_elems(vi);
    finish = 1'b1;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    check("elem6_before_reset", {out_valid, out_data}, {1'b1, 10'd6});
    rst = 1'b1;
    #1;
    check("async_reset_zero", {out_valid, out_data, out_row, out_col, busy, done, checksum}, 64'd0);
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(vi, 120, 0);

    // 5. Level-held finish: no re-trigger, then a fresh edge with new data
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("no_retrigger", {out_valid, busy}, 64'd0);
    end
    finish = 1'b0;
    @(posedge clk); #1;
    run(vn, 472, 0);

    // 6. finish already high when reset is released
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run(vs, 6000, 0);

    finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("elements_drained", exp_q.size(), 64'd0);
    check("checksums_drained", sum_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
